mem_channel_adapter: RTL and testbench
======================================

# mem_channel_adapter

Per-channel bridge between one memory channel and one `sspmv` PE port, on the memory side of the engine. It converts the engine's read-address stream (`RAddr`) into credit-limited memory read requests and returns in-order read data as `RData`/`RDataV`. It also buffers the engine's `WData`/`WDataV` stream into sequential-address memory writes and drives the `r_en`/`w_en` flow-control inputs. The top level instantiates one adapter per PE channel (16 in the 16-PE build).

## Interface
Parameters:
- `FIFO_WIDTH`, 768: read data word width.
- `WDATA_W`, 512: write data word width.
- `ADDR_W`, 32: address width.
- `MAX_OUT`, 16: maximum reads in flight; power of two.
- `REQ_DEPTH`, 4: read-request queue depth; power of two.
- `WF_DEPTH`, 8: write FIFO depth; power of two, at least 4.

Ports:
- `clk`, in, 1: clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `eng_raddr`, in, `ADDR_W`: engine read address (`RAddrN`).
- `eng_rd_fire`, in, 1: engine consumed a read credit this cycle (`r_en & ~FIFO_full`).
- `r_en`, out, 1: read credit available.
- `RData`, out, `FIFO_WIDTH`: read data to the engine.
- `RDataV`, out, 1: read data valid.
- `WData`, in, `WDATA_W`: engine write data.
- `WDataV`, in, 1: engine write data valid.
- `w_en`, out, 1: write space available.
- `mem_rd_req_valid` / `mem_rd_req_ready` / `mem_rd_req_addr`: out / in / out, 1 / 1 / `ADDR_W`: read request channel.
- `mem_rd_resp_valid` / `mem_rd_resp_data`: in / in, 1 / `FIFO_WIDTH`: in-order read responses; cannot be backpressured.
- `mem_wr_valid` / `mem_wr_ready` / `mem_wr_addr` / `mem_wr_data`: out / in / out / out, 1 / 1 / `ADDR_W` / `WDATA_W`: write channel.
- `wr_base`, in, `ADDR_W`: write base address.
- `wr_base_load`, in, 1: load the base and clear the write counter.
- `idle`, out, 1: nothing outstanding or buffered.
- `wr_overflow`, out, 1: sticky; a write was dropped.

## Operation
**Read credit**
- `out_cnt` (width log2(MAX_OUT)+1) counts accepted engine reads not yet answered.
- `r_en = ~rst & (out_cnt < MAX_OUT) & (req_cnt < REQ_DEPTH)`. It is combinational from registers only.

**Read request path**
- `eng_rd_fire` with `r_en=1` pushes `eng_raddr` into the request FIFO and increments `out_cnt`.
- `eng_rd_fire` with `r_en=0` is ignored: no push, no count change.
- The head of the FIFO drives `mem_rd_req_*`. It pops on `valid & ready`.
- Push and pop in the same cycle are legal. Occupancy is unchanged and the data stays in order.

**Read response path**
- Each `mem_rd_resp_valid` decrements `out_cnt`.
- Simultaneous fire and response leaves `out_cnt` unchanged.
- `RData`/`RDataV` are the response registered one stage. `RData` holds its value when `RDataV=0`.

**Write path**
- `WDataV=1` pushes `WData` into the `WF_DEPTH` FIFO.
- If the FIFO is full, the word is dropped and `wr_overflow` is set. It clears only on reset.
- `w_en` is registered: `1` when free entries ≥ 2 after the current edge. This absorbs one cycle of engine reaction latency.
- The FIFO head drives `mem_wr_data`. `mem_wr_addr = wr_base_q + wr_cnt`, with wrap modulo 2^`ADDR_W`.
- `wr_cnt` increments on each `mem_wr_valid & mem_wr_ready`.
- `wr_base_load` sets `wr_base_q <= wr_base` and `wr_cnt <= 0`. It wins over a simultaneous handshake.

**Status**
- `idle = (out_cnt==0) & req FIFO empty & write FIFO empty`.

## Timing
- Reset values:
  - `RDataV=0`, `RData=0`, `mem_rd_req_valid=0`, `mem_wr_valid=0`.
  - `w_en=0`, then `1` on the first edge after reset release.
  - `r_en=0` while `rst` is high.
  - `idle=1`, `wr_overflow=0`.
  - All counters, FIFOs and `wr_base_q` are zero.
- Read request latency: fire at edge t makes `mem_rd_req_valid=1` with that address after edge t.
- Read response latency: 1 cycle, response to `RDataV`.
- Write latency: `WDataV` at edge t gives `mem_wr_valid=1` after edge t, when the FIFO was empty.
- Reset asserted mid-operation discards all queued requests, in-flight counts and buffered writes immediately. Responses arriving after reset are not counted below zero: `out_cnt` saturates at 0.

## Test plan
- **Read burst, memory always ready.** Fire addresses 0x100..0x10F on consecutive cycles; responses return 3 cycles later. Required: request addresses in order, 16 `RDataV` pulses with matching data, `idle=1` at the end.
- **Read credit exhaustion.** Hold `mem_rd_req_ready=1`, never respond, fire every cycle. Required: `r_en` drops after the 16th fire; a 17th fire is ignored; one response restores `r_en=1`.
- **Request queue backpressure.** Hold `mem_rd_req_ready=0`. Required: `r_en=0` after 4 fires; releasing `ready` drains 4 requests in order.
- **Write stream.** `wr_base_load` with 0x2000, then 8 words with `mem_wr_ready` toggling 1/0. Required: addresses 0x2000..0x2007 in order, `w_en` low while free entries < 2.
- **Write overflow.** `mem_wr_ready=0`, 9 valid words. Required: 8 stored, `wr_overflow=1`, stored data unchanged.
- **Corner cases.** Load collides with a write handshake: next address is `wr_base+0`. Reset mid-burst: all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/mem_channel_adapter.sv
// mem_channel_adapter
// Bridges one memory channel to one sspmv PE port. Engine read addresses
// become credit-limited memory read requests, in-order read responses are
// returned one stage later as RData/RDataV, and the engine write stream is
// buffered into sequential-address memory writes.
module mem_channel_adapter #(
  parameter int FIFO_WIDTH = 768,
  parameter int WDATA_W    = 512,
  parameter int ADDR_W     = 32,
  parameter int MAX_OUT    = 16,
  parameter int REQ_DEPTH  = 4,
  parameter int WF_DEPTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // engine read side
  input  logic [ADDR_W-1:0]     eng_raddr,
  input  logic                  eng_rd_fire,
  output logic                  r_en,
  output logic [FIFO_WIDTH-1:0] RData,
  output logic                  RDataV,
  // engine write side
  input  logic [WDATA_W-1:0]    WData,
  input  logic                  WDataV,
  output logic                  w_en,
  // memory read request channel
  output logic                  mem_rd_req_valid,
  input  logic                  mem_rd_req_ready,
  output logic [ADDR_W-1:0]     mem_rd_req_addr,
  // memory read response channel (never backpressured)
  input  logic                  mem_rd_resp_valid,
  input  logic [FIFO_WIDTH-1:0] mem_rd_resp_data,
  // memory write channel
  output logic                  mem_wr_valid,
  input  logic                  mem_wr_ready,
  output logic [ADDR_W-1:0]     mem_wr_addr,
  output logic [WDATA_W-1:0]    mem_wr_data,
  // write address control
  input  logic [ADDR_W-1:0]     wr_base,
  input  logic                  wr_base_load,
  // status
  output logic                  idle,
  output logic                  wr_overflow
);

  localparam int OUT_W  = $clog2(MAX_OUT) + 1;
  localparam int REQ_AW = $clog2(REQ_DEPTH);
  localparam int REQ_CW = REQ_AW + 1;
  localparam int WF_AW  = $clog2(WF_DEPTH);
  localparam int WF_CW  = WF_AW + 1;

  localparam logic [OUT_W-1:0]  OUT_MAX  = OUT_W'(MAX_OUT);
  localparam logic [REQ_CW-1:0] REQ_FULL = REQ_CW'(REQ_DEPTH);
  localparam logic [WF_CW-1:0]  WF_FULL  = WF_CW'(WF_DEPTH);
  localparam logic [WF_CW-1:0]  WF_TWO   = WF_CW'(2);

  // ---------------------------------------------------------------
  // Read side state
  // ---------------------------------------------------------------
  logic [OUT_W-1:0]  out_cnt;
  logic [OUT_W-1:0]  out_cnt_nxt;
  logic [ADDR_W-1:0] req_mem [REQ_DEPTH];
  logic [REQ_AW-1:0] req_wr_ptr;
  logic [REQ_AW-1:0] req_rd_ptr;
  logic [REQ_CW-1:0] req_cnt;
  logic [REQ_CW-1:0] req_cnt_nxt;
  logic              rd_push;
  logic              rd_pop;

  // ---------------------------------------------------------------
  // Write side state
  // ---------------------------------------------------------------
  logic [WDATA_W-1:0] wf_mem [WF_DEPTH];
  logic [WF_AW-1:0]   wf_wr_ptr;
  logic [WF_AW-1:0]   wf_rd_ptr;
  logic [WF_CW-1:0]   wf_cnt;
  logic [WF_CW-1:0]   wf_cnt_nxt;
  logic               wf_full;
  logic               wf_push;
  logic               wf_pop;
  logic [ADDR_W-1:0]  wr_base_q;
  logic [ADDR_W-1:0]  wr_cnt;

  // A credit is offered only when both the in-flight budget and the request
  // queue have room; holding it low during reset keeps the engine quiet.
  assign r_en    = ~rst & (out_cnt < OUT_MAX) & (req_cnt < REQ_FULL);
  assign rd_push = eng_rd_fire & r_en;
  assign rd_pop  = mem_rd_req_valid & mem_rd_req_ready;

  assign mem_rd_req_valid = (req_cnt != '0);
  assign mem_rd_req_addr  = req_mem[req_rd_ptr];

  // Next request-queue occupancy; a simultaneous push and pop cancel out.
  always_comb begin
    req_cnt_nxt = req_cnt;
    case ({rd_push, rd_pop})
      2'b10:   req_cnt_nxt = req_cnt + REQ_CW'(1);
      2'b01:   req_cnt_nxt = req_cnt - REQ_CW'(1);
      default: req_cnt_nxt = req_cnt;
    endcase
  end

  // Request queue storage and pointers; the head entry is the live request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_wr_ptr <= '0;
      req_rd_ptr <= '0;
      req_cnt    <= '0;
      for (int i = 0; i < REQ_DEPTH; i++) begin
        req_mem[i] <= '0;
      end
    end else begin
      if (rd_push) begin
        req_mem[req_wr_ptr] <= eng_raddr;
        req_wr_ptr          <= req_wr_ptr + REQ_AW'(1);
      end
      if (rd_pop) begin
        req_rd_ptr <= req_rd_ptr + REQ_AW'(1);
      end
      req_cnt <= req_cnt_nxt;
    end
  end

  // In-flight count: up on an accepted fire, down on a response. A response
  // with nothing outstanding (e.g. one that straddled a reset) is absorbed
  // at zero instead of wrapping.
  always_comb begin
    out_cnt_nxt = out_cnt;
    case ({rd_push, mem_rd_resp_valid})
      2'b10:   out_cnt_nxt = out_cnt + OUT_W'(1);
      2'b01:   out_cnt_nxt = (out_cnt == '0) ? out_cnt : out_cnt - OUT_W'(1);
      default: out_cnt_nxt = out_cnt;
    endcase
  end

  // Register the in-flight count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_cnt <= '0;
    end else begin
      out_cnt <= out_cnt_nxt;
    end
  end

  // Responses are forwarded one stage later; the data register only loads on
  // a valid response so RData holds its last value between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RDataV <= 1'b0;
      RData  <= '0;
    end else begin
      RDataV <= mem_rd_resp_valid;
      if (mem_rd_resp_valid) begin
        RData <= mem_rd_resp_data;
      end
    end
  end

  // Write FIFO: a word arriving while the FIFO is full is dropped, even if
  // the head drains on the same edge, so the overflow rule stays simple.
  assign wf_full      = (wf_cnt == WF_FULL);
  assign wf_push      = WDataV & ~wf_full;
  assign mem_wr_valid = (wf_cnt != '0);
  assign wf_pop       = mem_wr_valid & mem_wr_ready;
  assign mem_wr_data  = wf_mem[wf_rd_ptr];
  assign mem_wr_addr  = wr_base_q + wr_cnt;

  // Next write-FIFO occupancy; also feeds the registered w_en look-ahead.
  always_comb begin
    wf_cnt_nxt = wf_cnt;
    case ({wf_push, wf_pop})
      2'b10:   wf_cnt_nxt = wf_cnt + WF_CW'(1);
      2'b01:   wf_cnt_nxt = wf_cnt - WF_CW'(1);
      default: wf_cnt_nxt = wf_cnt;
    endcase
  end

  // Write FIFO storage and pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wf_wr_ptr <= '0;
      wf_rd_ptr <= '0;
      wf_cnt    <= '0;
      for (int i = 0; i < WF_DEPTH; i++) begin
        wf_mem[i] <= '0;
      end
    end else begin
      if (wf_push) begin
        wf_mem[wf_wr_ptr] <= WData;
        wf_wr_ptr         <= wf_wr_ptr + WF_AW'(1);
      end
      if (wf_pop) begin
        wf_rd_ptr <= wf_rd_ptr + WF_AW'(1);
      end
      wf_cnt <= wf_cnt_nxt;
    end
  end

  // w_en keeps one spare entry beyond the next word so that a word the
  // engine launches in the cycle it sees w_en fall still has a slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_en <= 1'b0;
    end else begin
      w_en <= ((WF_FULL - wf_cnt_nxt) >= WF_TWO);
    end
  end

  // Sticky flag recording that at least one engine write was lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_overflow <= 1'b0;
    end else if (WDataV && wf_full) begin
      wr_overflow <= 1'b1;
    end
  end

  // Write address generator; a base load restarts the sequence and takes
  // priority over a handshake on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_base_q <= '0;
      wr_cnt    <= '0;
    end else if (wr_base_load) begin
      wr_base_q <= wr_base;
      wr_cnt    <= '0;
    end else if (wf_pop) begin
      wr_cnt <= wr_cnt + ADDR_W'(1);
    end
  end

  assign idle = (out_cnt == '0) & (req_cnt == '0) & (wf_cnt == '0);

endmodule

// File: tb/tb_mem_channel_adapter.sv
// Directed testbench for mem_channel_adapter with hand-computed expectations.
module tb_mem_channel_adapter;

  localparam int FW = 768;
  localparam int WW = 512;
  localparam int AW = 32;

  logic          clk;
  logic          rst;
  logic [AW-1:0] eng_raddr;
  logic          eng_rd_fire;
  logic          r_en;
  logic [FW-1:0] RData;
  logic          RDataV;
  logic [WW-1:0] WData;
  logic          WDataV;
  logic          w_en;
  logic          mem_rd_req_valid;
  logic          mem_rd_req_ready;
  logic [AW-1:0] mem_rd_req_addr;
  logic          mem_rd_resp_valid;
  logic [FW-1:0] mem_rd_resp_data;
  logic          mem_wr_valid;
  logic          mem_wr_ready;
  logic [AW-1:0] mem_wr_addr;
  logic [WW-1:0] mem_wr_data;
  logic [AW-1:0] wr_base;
  logic          wr_base_load;
  logic          idle;
  logic          wr_overflow;

  int vec_cnt = 0;
  int err_cnt = 0;

  mem_channel_adapter dut (
    .clk(clk), .rst(rst),
    .eng_raddr(eng_raddr), .eng_rd_fire(eng_rd_fire), .r_en(r_en),
    .RData(RData), .RDataV(RDataV),
    .WData(WData), .WDataV(WDataV), .w_en(w_en),
    .mem_rd_req_valid(mem_rd_req_valid), .mem_rd_req_ready(mem_rd_req_ready),
    .mem_rd_req_addr(mem_rd_req_addr),
    .mem_rd_resp_valid(mem_rd_resp_valid), .mem_rd_resp_data(mem_rd_resp_data),
    .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .wr_base(wr_base), .wr_base_load(wr_base_load),
    .idle(idle), .wr_overflow(wr_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read data pattern derived from the request address.
  function automatic logic [FW-1:0] rpat(input logic [AW-1:0] a);
    return {24{a ^ 32'hA5A5_0000}};
  endfunction

  // Write data pattern derived from a word index and a tag.
  function automatic logic [WW-1:0] wpat(input logic [15:0] tag, input int n);
    logic [31:0] w;
    w = {tag, 16'(n)};
    return {16{w}};
  endfunction

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic applyStimulus;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    eng_raddr = '0; eng_rd_fire = 1'b0; WData = '0; WDataV = 1'b0;
    mem_rd_req_ready = 1'b0; mem_rd_resp_valid = 1'b0; mem_rd_resp_data = '0;
    mem_wr_ready = 1'b0; wr_base = '0; wr_base_load = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clear_inputs();
    applyStimulus();
    applyStimulus();
    vec_cnt++; if (r_en !== 1'b0) begin err_cnt++; $display("[TB] FAIL rst_r_en: got %b want 0", r_en); end
    vec_cnt++; if (RDataV !== 1'b0) begin err_cnt++; $display("[TB] FAIL rst_rdatav: got %b want 0", RDataV); end
    vec_cnt++; if (RData !== '0) begin err_cnt++; $display("[TB] FAIL rst_rdata: got %h want 0", RData); end
    vec_cnt++; if (mem_rd_req_valid !== 1'b0) begin err_cnt++; $display("[TB] FAIL rst_req_valid: got %b want 0", mem_rd_req_valid); end
    vec_cnt++; if (mem_wr_valid !== 1'b0) begin err_cnt++; $display("[TB] FAIL rst_wr_valid: got %b want 0", mem_wr_valid); end
    vec_cnt++; if (w_en !== 1'b0) begin err_cnt++; $display("[TB] FAIL rst_w_en: got %b want 0", w_en); end
    vec_cnt++; if (idle !== 1'b1) begin err_cnt++; $display("[TB] FAIL rst_idle: got %b want 1", idle); end
    vec_cnt++; if (wr_overflow !== 1'b0) begin err_cnt++; $display("[TB] FAIL rst_overflow: got %b want 0", wr_overflow); end
    rst = 1'b0;
    #1;
    vec_cnt++; if (w_en !== 1'b0) begin err_cnt++; $display("[TB] FAIL release_w_en: got %b want 0", w_en); end
    vec_cnt++; if (r_en !== 1'b1) begin err_cnt++; $display("[TB] FAIL release_r_en: got %b want 1", r_en); end
    applyStimulus();
    vec_cnt++; if (w_en !== 1'b1) begin err_cnt++; $display("[TB] FAIL first_edge_w_en: got %b want 1", w_en); end
  endtask

  // 16 back-to-back fires, memory always ready, responses 3 cycles later.
  task automatic test_read_burst;
    mem_rd_req_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) begin
        vec_cnt++; if (r_en !== 1'b1) begin err_cnt++; $display("[TB] FAIL burst_r_en[%0d]: got %b want 1", i, r_en); end
      end
      eng_rd_fire = (i < 16);
      eng_raddr = 32'h100 + 32'(i);
      mem_rd_resp_valid = (i >= 3 && i < 19);
      mem_rd_resp_data = rpat(32'h100 + 32'(i - 3));
      applyStimulus();
      if (i < 16) begin
        vec_cnt++; if (mem_rd_req_valid !== 1'b1 || mem_rd_req_addr !== 32'h100 + 32'(i)) begin
          err_cnt++; $display("[TB] FAIL burst_req[%0d]: got v=%b a=%h want v=1 a=%h", i, mem_rd_req_valid, mem_rd_req_addr, 32'h100 + 32'(i)); end
      end else begin
        vec_cnt++; if (mem_rd_req_valid !== 1'b0) begin err_cnt++; $display("[TB] FAIL burst_req_empty[%0d]: got %b want 0", i, mem_rd_req_valid); end
      end
      if (i >= 3 && i < 19) begin
        vec_cnt++; if (RDataV !== 1'b1 || RData !== rpat(32'h100 + 32'(i - 3))) begin
          err_cnt++; $display("[TB] FAIL burst_rdata[%0d]: got v=%b d=%h want v=1 d=%h", i - 3, RDataV, RData, rpat(32'h100 + 32'(i - 3))); end
      end else begin
        vec_cnt++; if (RDataV !== 1'b0) begin err_cnt++; $display("[TB] FAIL burst_rdatav_low[%0d]: got %b want 0", i, RDataV); end
      end
    end
    clear_inputs();
    vec_cnt++; if (idle !== 1'b1) begin err_cnt++; $display("[TB] FAIL burst_idle: got %b want 1", idle); end
  endtask

  // Fire until credits run out, try one more, then restore with a response.
  task automatic test_credit_exhaustion;
    mem_rd_req_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      vec_cnt++; if (r_en !== 1'b1) begin err_cnt++; $display("[TB] FAIL credit_r_en[%0d]: got %b want 1", i, r_en); end
      eng_rd_fire = 1'b1;
      eng_raddr = 32'h300 + 32'(i);
      applyStimulus();
    end
    vec_cnt++; if (r_en !== 1'b0) begin err_cnt++; $display("[TB] FAIL credit_exhausted: got %b want 0", r_en); end
    eng_raddr = 32'h3FF;
    applyStimulus();
    eng_rd_fire = 1'b0;
    vec_cnt++; if (mem_rd_req_valid !== 1'b0) begin err_cnt++; $display("[TB] FAIL credit_ignored_push: got %b want 0", mem_rd_req_valid); end
    vec_cnt++; if (r_en !== 1'b0) begin err_cnt++; $display("[TB] FAIL credit_still_low: got %b want 0", r_en); end
    mem_rd_resp_valid = 1'b1;
    mem_rd_resp_data = rpat(32'h300);
    applyStimulus();
    vec_cnt++; if (r_en !== 1'b1) begin err_cnt++; $display("[TB] FAIL credit_restored: got %b want 1", r_en); end
    vec_cnt++; if (RDataV !== 1'b1 || RData !== rpat(32'h300)) begin
      err_cnt++; $display("[TB] FAIL credit_rdata: got v=%b d=%h want v=1 d=%h", RDataV, RData, rpat(32'h300)); end
    for (int i = 1; i < 16; i++) begin
      mem_rd_resp_data = rpat(32'h300 + 32'(i));
      applyStimulus();
    end
    mem_rd_resp_valid = 1'b0;
    applyStimulus();
    vec_cnt++; if (idle !== 1'b1) begin err_cnt++; $display("[TB] FAIL credit_idle: got %b want 1", idle); end
    clear_inputs();
  endtask

  // Stall the request channel until the queue fills, then drain in order.
  task automatic test_req_backpressure;
    mem_rd_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vec_cnt++; if (r_en !== 1'b1) begin err_cnt++; $display("[TB] FAIL bp_r_en[%0d]: got %b want 1", i, r_en); end
      eng_rd_fire = 1'b1;
      eng_raddr = 32'h400 + 32'(i);
      applyStimulus();
    end
    eng_rd_fire = 1'b0;
    vec_cnt++; if (r_en !== 1'b0) begin err_cnt++; $display("[TB] FAIL bp_queue_full: got %b want 0", r_en); end
    mem_rd_req_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vec_cnt++; if (mem_rd_req_valid !== 1'b1 || mem_rd_req_addr !== 32'h400 + 32'(k)) begin
        err_cnt++; $display("[TB] FAIL bp_drain[%0d]: got v=%b a=%h want v=1 a=%h", k, mem_rd_req_valid, mem_rd_req_addr, 32'h400 + 32'(k)); end
      applyStimulus();
    end
    vec_cnt++; if (mem_rd_req_valid !== 1'b0) begin err_cnt++; $display("[TB] FAIL bp_drained: got %b want 0", mem_rd_req_valid); end
    vec_cnt++; if (r_en !== 1'b1) begin err_cnt++; $display("[TB] FAIL bp_r_en_back: got %b want 1", r_en); end
    vec_cnt++; if (idle !== 1'b0) begin err_cnt++; $display("[TB] FAIL bp_busy: got %b want 0", idle); end
    mem_rd_req_ready = 1'b0;
    mem_rd_resp_valid = 1'b1;
    repeat (4) applyStimulus();
    mem_rd_resp_valid = 1'b0;
    vec_cnt++; if (idle !== 1'b1) begin err_cnt++; $display("[TB] FAIL bp_idle: got %b want 1", idle); end
  endtask

  // Load base 0x2000 and stream 8 words while mem_wr_ready toggles 1/0.
  task automatic test_write_stream;
    wr_base = 32'h2000;
    wr_base_load = 1'b1;
    applyStimulus();
    wr_base_load = 1'b0;
    vec_cnt++; if (mem_wr_valid !== 1'b0) begin err_cnt++; $display("[TB] FAIL ws_start_valid: got %b want 0", mem_wr_valid); end
    for (int c = 0; c <= 16; c++) begin
      WDataV = (c < 8);
      WData = wpat(16'hC0DE, c);
      mem_wr_ready = (c % 2 == 0);
      vec_cnt++; if (w_en !== 1'b1) begin err_cnt++; $display("[TB] FAIL ws_w_en[%0d]: got %b want 1", c, w_en); end
      if (c >= 2 && c % 2 == 0) begin
        vec_cnt++; if (mem_wr_valid !== 1'b1 || mem_wr_addr !== 32'h2000 + 32'((c - 2) / 2) || mem_wr_data !== wpat(16'hC0DE, (c - 2) / 2)) begin
          err_cnt++; $display("[TB] FAIL ws_write[%0d]: got v=%b a=%h d=%h want a=%h", (c - 2) / 2, mem_wr_valid, mem_wr_addr, mem_wr_data[31:0], 32'h2000 + 32'((c - 2) / 2)); end
      end
      applyStimulus();
    end
    clear_inputs();
    vec_cnt++; if (mem_wr_valid !== 1'b0) begin err_cnt++; $display("[TB] FAIL ws_empty: got %b want 0", mem_wr_valid); end
    vec_cnt++; if (idle !== 1'b1) begin err_cnt++; $display("[TB] FAIL ws_idle: got %b want 1", idle); end
  endtask

  // Overfill a stalled FIFO, then drain it with a base load colliding with a
  // handshake partway through.
  task automatic test_write_overflow;
    mem_wr_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      WDataV = 1'b1;
      WData = wpat(16'hBEEF, k);
      applyStimulus();
      vec_cnt++; if (w_en !== (k < 6)) begin err_cnt++; $display("[TB] FAIL ov_w_en[%0d]: got %b want %b", k, w_en, (k < 6)); end
      vec_cnt++; if (wr_overflow !== (k == 8)) begin err_cnt++; $display("[TB] FAIL ov_flag[%0d]: got %b want %b", k, wr_overflow, (k == 8)); end
    end
    WDataV = 1'b0;
    vec_cnt++; if (idle !== 1'b0) begin err_cnt++; $display("[TB] FAIL ov_busy: got %b want 0", idle); end
    mem_wr_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      logic [AW-1:0] exp_a;
      exp_a = (j <= 3) ? 32'h2008 + 32'(j) : 32'h5000 + 32'(j - 4);
      vec_cnt++; if (mem_wr_valid !== 1'b1 || mem_wr_addr !== exp_a || mem_wr_data !== wpat(16'hBEEF, j)) begin
        err_cnt++; $display("[TB] FAIL ov_drain[%0d]: got v=%b a=%h d=%h want a=%h d=%h", j, mem_wr_valid, mem_wr_addr, mem_wr_data[31:0], exp_a, wpat(16'hBEEF, j) & 512'hFFFF_FFFF); end
      wr_base_load = (j == 3);
      wr_base = 32'h5000;
      applyStimulus();
      wr_base_load = 1'b0;
    end
    clear_inputs();
    vec_cnt++; if (mem_wr_valid !== 1'b0) begin err_cnt++; $display("[TB] FAIL ov_drained: got %b want 0", mem_wr_valid); end
    vec_cnt++; if (wr_overflow !== 1'b1) begin err_cnt++; $display("[TB] FAIL ov_sticky: got %b want 1", wr_overflow); end
  endtask

  // Reset in the middle of activity, then a stray response after release.
  task automatic test_reset_mid_burst;
    mem_rd_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      eng_rd_fire = 1'b1;
      eng_raddr = 32'h600 + 32'(i);
      WDataV = 1'b1;
      WData = wpat(16'h7777, i);
      mem_rd_resp_valid = (i == 2);
      mem_rd_resp_data = rpat(32'h600);
      applyStimulus();
    end
    clear_inputs();
    vec_cnt++; if (RDataV !== 1'b1 || mem_rd_req_valid !== 1'b1 || mem_wr_valid !== 1'b1) begin
      err_cnt++; $display("[TB] FAIL mid_busy: got rv=%b qv=%b wv=%b want 1 1 1", RDataV, mem_rd_req_valid, mem_wr_valid); end
    #2;
    rst = 1'b1;
    #1;
    vec_cnt++; if (r_en !== 1'b0) begin err_cnt++; $display("[TB] FAIL mid_r_en: got %b want 0", r_en); end
    vec_cnt++; if (RDataV !== 1'b0 || RData !== '0) begin err_cnt++; $display("[TB] FAIL mid_rdata: got v=%b d=%h want 0", RDataV, RData); end
    vec_cnt++; if (mem_rd_req_valid !== 1'b0 || mem_rd_req_addr !== '0) begin
      err_cnt++; $display("[TB] FAIL mid_req: got v=%b a=%h want 0 0", mem_rd_req_valid, mem_rd_req_addr); end
    vec_cnt++; if (mem_wr_valid !== 1'b0 || mem_wr_addr !== '0) begin
      err_cnt++; $display("[TB] FAIL mid_wr: got v=%b a=%h want 0 0", mem_wr_valid, mem_wr_addr); end
    vec_cnt++; if (w_en !== 1'b0) begin err_cnt++; $display("[TB] FAIL mid_w_en: got %b want 0", w_en); end
    vec_cnt++; if (idle !== 1'b1) begin err_cnt++; $display("[TB] FAIL mid_idle: got %b want 1", idle); end
    vec_cnt++; if (wr_overflow !== 1'b0) begin err_cnt++; $display("[TB] FAIL mid_overflow: got %b want 0", wr_overflow); end
    applyStimulus();
    rst = 1'b0;
    mem_rd_resp_valid = 1'b1;
    mem_rd_resp_data = rpat(32'h601);
    applyStimulus();
    mem_rd_resp_valid = 1'b0;
    vec_cnt++; if (r_en !== 1'b1) begin err_cnt++; $display("[TB] FAIL late_resp_r_en: got %b want 1", r_en); end
    vec_cnt++; if (idle !== 1'b1) begin err_cnt++; $display("[TB] FAIL late_resp_idle: got %b want 1", idle); end
    vec_cnt++; if (w_en !== 1'b1) begin err_cnt++; $display("[TB] FAIL late_w_en: got %b want 1", w_en); end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_read_burst();
    test_credit_exhaustion();
    test_req_backpressure();
    test_write_stream();
    test_write_overflow();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
